// File: rtl/uart_mmio.sv
// Memory-mapped UART stage: TX/RX byte FIFOs, sticky ovf/unf flags, registered read data.
// Define UART_MMIO_COUNTERS_EN to add cycle / TX-byte counters at 0x80000010..18.
module uart_mmio #(
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    output logic [31:0] rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);
    localparam int TPW = $clog2(TX_DEPTH);
    localparam int RPW = $clog2(RX_DEPTH);
    localparam logic [TPW:0] TX_FULL = (TPW+1)'(TX_DEPTH);
    localparam logic [RPW:0] RX_FULL = (RPW+1)'(RX_DEPTH);

    localparam logic [31:0] A_CTL  = 32'h8000_0000;
    localparam logic [31:0] A_RXST = 32'h8000_0004;
    localparam logic [31:0] A_TXD  = 32'h8000_0008;
    localparam logic [31:0] A_RXD  = 32'h8000_000C;

    logic [7:0]     tx_mem [TX_DEPTH];
    logic [TPW-1:0] tx_wp, tx_rp;
    logic [TPW:0]   tx_count;
    logic [7:0]     rx_mem [RX_DEPTH];
    logic [RPW-1:0] rx_wp, rx_rp;
    logic [RPW:0]   rx_count;
    logic           tx_ovf, rx_unf;

    logic unused_wdata;
    assign unused_wdata = ^wdata[31:8];

    logic ctl_wr, tx_push, tx_acc, tx_drain, rd_pop, rx_enq, rx_pop, rx_uf;
    assign ctl_wr   = we && (addr == A_CTL);
    assign tx_push  = we && (addr == A_TXD);
    assign tx_acc   = tx_push && (tx_count < TX_FULL);
    assign tx_valid = (tx_count != '0);
    assign tx_data  = tx_mem[tx_rp];
    assign tx_drain = tx_valid && tx_ready;

    assign rx_ready = (rx_count < RX_FULL);
    assign rx_enq   = rx_valid && rx_ready;
    assign rd_pop   = re && (addr == A_RXD);
    assign rx_pop   = rd_pop && (rx_count != '0);
    assign rx_uf    = rd_pop && (rx_count == '0);

    // Storage arrays carry no reset: pointers/counts define what is valid.
    always_ff @(posedge clk) begin
        if (tx_acc) tx_mem[tx_wp] <= wdata[7:0];
        if (rx_enq) rx_mem[rx_wp] <= rx_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_wp    <= '0;
            tx_rp    <= '0;
            tx_count <= '0;
            rx_wp    <= '0;
            rx_rp    <= '0;
            rx_count <= '0;
            tx_ovf   <= 1'b0;
            rx_unf   <= 1'b0;
        end else begin
            if (tx_acc)   tx_wp <= tx_wp + 1'b1;
            if (tx_drain) tx_rp <= tx_rp + 1'b1;
            if (tx_acc && !tx_drain)      tx_count <= tx_count + 1'b1;
            else if (!tx_acc && tx_drain) tx_count <= tx_count - 1'b1;

            if (rx_enq) rx_wp <= rx_wp + 1'b1;
            if (rx_pop) rx_rp <= rx_rp + 1'b1;
            if (rx_enq && !rx_pop)      rx_count <= rx_count + 1'b1;
            else if (!rx_enq && rx_pop) rx_count <= rx_count - 1'b1;

            // A new event in the same cycle as a clear keeps the flag set.
            if (tx_push && !tx_acc)     tx_ovf <= 1'b1;
            else if (ctl_wr && wdata[1]) tx_ovf <= 1'b0;
            if (rx_uf)                  rx_unf <= 1'b1;
            else if (ctl_wr && wdata[0]) rx_unf <= 1'b0;
        end
    end

`ifdef UART_MMIO_COUNTERS_EN
    logic [31:0] cyc_cnt, txb_cnt;
    logic        cnt_clr;
    assign cnt_clr = we && (addr == 32'h8000_0018);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc_cnt <= '0;
            txb_cnt <= '0;
        end else if (cnt_clr) begin
            cyc_cnt <= '0;
            txb_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
            if (tx_drain) txb_cnt <= txb_cnt + 32'd1;
        end
    end
`endif

    logic [31:0] rd_nxt;
    always_comb begin
        rd_nxt = '0;
        case (addr)
            A_CTL:  rd_nxt = {29'b0, tx_ovf, rx_unf, (tx_count < TX_FULL)};
            A_RXST: rd_nxt = {31'b0, (rx_count != '0)};
            A_RXD:  if (rx_count != '0) rd_nxt = {24'b0, rx_mem[rx_rp]};
`ifdef UART_MMIO_COUNTERS_EN
            32'h8000_0010: rd_nxt = cyc_cnt;
            32'h8000_0014: rd_nxt = txb_cnt;
`endif
            default: rd_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rdata <= '0;
        else          rdata <= rd_nxt;
    end
endmodule

// File: doc/uart_mmio.md
Name: uart_mmio

Overview:
- Memory-mapped UART I/O stage directly downstream of the CPU control decoder.
- Consumes the decoded UART write and read strobes plus the memory-stage address and store data.
- Buffers bytes in small TX/RX FIFOs, drives a ready/valid byte interface to the UART core, and returns registered read data to the writeback mux.

Parameters:
- TX_DEPTH, 4, TX FIFO entries; power of 2, >= 2.
- RX_DEPTH, 4, RX FIFO entries; power of 2, >= 2.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- addr  in  32  memory-stage byte address.
- wdata  in  32  store data; only [7:0] is used for TX, plus [1:0] for flag clears.
- we  in  1  UART write strobe (WEUART).
- re  in  1  UART read-pop strobe (REUART); only acts at 0x8000000C.
- rdata  out  32  registered read data to the writeback mux.
- tx_data  out  8  byte to UART transmitter.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  transmitter accepts the byte this cycle.
- rx_data  in  8  byte from UART receiver.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  block accepts rx_data this cycle.

Behaviour:
- Reset (async, reset_n=0):
  - Both FIFOs empty; pointers and counts 0; overflow/underflow flags 0.
  - rdata=0, tx_valid=0, rx_ready=1 once reset is released.
  - Reset asserted mid-transfer drops all buffered bytes immediately.
- Register map (full 32-bit address compare):
  - 0x80000000 R: {29'b0, tx_ovf, rx_unf, tx_not_full}.
  - 0x80000000 W: wdata[1]=1 clears tx_ovf; wdata[0]=1 clears rx_unf.
  - 0x80000004 R: {31'b0, rx_not_empty}.
  - 0x80000008 W: push wdata[7:0] into the TX FIFO.
  - 0x8000000C R: {24'b0, RX head byte}; re=1 pops the head.
  - Any other address: reads 0; writes ignored.
- Read latency:
  - rdata is registered. It reflects addr and state sampled at edge N and is visible after edge N.
  - Pop at edge N: rdata gets the pre-pop head.
- TX FIFO:
  - Push accepted only if count < TX_DEPTH at the start of the cycle. No full-bypass, even if a drain happens the same cycle.
  - Push while full: byte dropped, tx_ovf<=1 (sticky).
  - tx_valid = (tx_count != 0); tx_data = head. No empty-bypass: push into empty FIFO gives tx_valid=1 one cycle later.
  - Drain when tx_valid && tx_ready.
  - Simultaneous accepted push and drain: count unchanged.
- RX FIFO:
  - rx_ready = (rx_count < RX_DEPTH).
  - Enqueue when rx_valid && rx_ready.
  - Pop on re at 0x8000000C when count != 0.
  - Pop while empty: rdata=0, no pointer change, rx_unf<=1 (sticky).
  - Simultaneous enqueue and pop at count=RX_DEPTH: rx_ready is already 0, so pop only.
  - Simultaneous enqueue and pop at count=0: pop is an underflow and the enqueue is stored; no bypass.
- Pointers: log2(DEPTH) bits, natural wrap-around. Counts: log2(DEPTH)+1 bits.
- Flag precedence: if a clear write and a new ovf/unf event hit the same cycle, set wins.
- we and re together are legal only at different addresses; each acts independently.

Optional Feature:
- Macro UART_MMIO_COUNTERS_EN.
- When defined, adds:
  - 32-bit free-running cycle counter, read at 0x80000010.
  - 32-bit TX-byte counter, read at 0x80000014; increments on each TX drain.
  - Any write to 0x80000018 zeroes both counters on that edge; the write wins over an increment in the same cycle.
  - Both counters reset to 0; 32-bit natural wrap.
- When undefined: 0x80000010/14/18 behave as unmapped (read 0, writes ignored), and no counter logic is synthesized.

Test Plan:
- Reset, then read 0x80000000 and 0x80000004 -> rdata 0x00000001 then 0x00000000; tx_valid=0, rx_ready=1.
- tx_ready=0; write 0x41,0x42,0x43,0x44,0x45 to 0x80000008 -> 4 stored, status read = 0x00000004. Raise tx_ready -> tx_data 0x41..0x44 on consecutive cycles, then tx_valid=0.
- Drive rx bytes 0x10,0x20 -> 0x80000004 reads 1. Two re reads of 0x8000000C -> rdata 0x10, 0x20. Third re -> rdata 0, status = 0x00000003 (rx_unf, tx_not_full). Write 0x1 to 0x80000000 -> rx_unf cleared.
- Fill RX with 4 bytes while holding rx_valid -> rx_ready=0 on the cycle after the 4th byte. One pop -> rx_ready=1 next cycle, and the 5th byte is accepted.
- Pull reset_n low with 3 bytes in TX and tx_ready=0 -> tx_valid=0 immediately (async). After release, tx_valid stays 0.
- With UART_MMIO_COUNTERS_EN: after 100 cycles read 0x80000010 -> about 100 (exact value per the bench's edge count). Write 0x80000018 -> next read returns 1.
